// File: rtl/parity_arbiter_pkg.sv
// Shared types and defaults for the round-robin parity arbiter.
package parity_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    RESP  = 2'd2
  } state_t;

  localparam int DEF_NREQ    = 4;
  localparam int DEF_COUNT_W = 8;

  // Width of a requester index; never narrower than one bit.
  function automatic int id_width(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/parity_arbiter_if.sv
// Requester-side bus of the parity arbiter: requests, nibbles, grants and responses.
interface parity_arbiter_if
  import parity_arb_pkg::*;
#(
  parameter int NREQ    = DEF_NREQ,
  parameter int COUNT_W = DEF_COUNT_W
) ();

  localparam int IDW = id_width(NREQ);

  logic                 en;
  logic [NREQ-1:0]      req;
  logic [4*NREQ-1:0]    data;
  logic [NREQ-1:0]      gnt;
  logic                 resp_valid;
  logic [IDW-1:0]       resp_id;
  logic                 resp_odd;
  logic                 led;
  logic [COUNT_W-1:0]   odd_count;

  modport master (
    output en, req, data,
    input  gnt, resp_valid, resp_id, resp_odd, led, odd_count
  );

  modport slave (
    input  en, req, data,
    output gnt, resp_valid, resp_id, resp_odd, led, odd_count
  );

endinterface

// File: rtl/parity_arbiter_odd_parity4.sv
// Combinational 4-bit odd-parity evaluator; the single resource the requesters share.
module odd_parity4 (
  input  logic [3:0] nib,
  output logic       odd
);

  assign odd = ^nib;

endmodule

// File: rtl/parity_arbiter.sv
// Round-robin arbiter granting one requester at a time access to a shared
// odd-parity evaluator; returns a tagged one-cycle response, drives the LED
// with the latest result and counts odd results (saturating).
module parity_arbiter
  import parity_arb_pkg::*;
#(
  parameter int NREQ    = DEF_NREQ,
  parameter int COUNT_W = DEF_COUNT_W
) (
  input  logic                 clk,
  input  logic                 rst,
  parity_arbiter_if.slave      bus
);

  localparam int IDW = id_width(NREQ);

  state_t               state_reg, state_next;
  logic [IDW-1:0]       ptr_reg;
  logic [IDW-1:0]       winner_reg;
  logic [IDW-1:0]       pick;
  logic [3:0]           operand_reg;
  logic [IDW-1:0]       resp_id_reg;
  logic                 resp_odd_reg;
  logic                 led_reg;
  logic [COUNT_W-1:0]   count_reg;
  logic                 parity;
  logic                 take;

  // First asserted request at or after the pointer, wrapping at NREQ.
  function automatic logic [IDW-1:0] rr_pick(input logic [NREQ-1:0] r,
                                             input logic [IDW-1:0]  p);
    logic [IDW-1:0] sel;
    logic           hit;
    sel = '0;
    hit = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      int idx;
      idx = int'(p) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!hit && r[idx]) begin
        hit = 1'b1;
        sel = IDW'(idx);
      end
    end
    return sel;
  endfunction

  assign take = bus.en && (|bus.req);
  assign pick = rr_pick(bus.req, ptr_reg);

  odd_parity4 u_parity (
    .nib (operand_reg),
    .odd (parity)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  // Next-state: only the IDLE decision depends on inputs; GRANT and RESP always advance.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (take) state_next = GRANT;
      GRANT:   state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Capture the winner's nibble and advance the round-robin pointer past it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_reg     <= '0;
      winner_reg  <= '0;
      operand_reg <= '0;
    end else if (state_reg == IDLE && take) begin
      operand_reg <= bus.data[4*int'(pick) +: 4];
      winner_reg  <= pick;
      ptr_reg     <= (pick == IDW'(NREQ-1)) ? '0 : pick + 1'b1;
    end
  end

  // Response, LED and counter update on the GRANT->RESP edge; held otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      resp_id_reg  <= '0;
      resp_odd_reg <= 1'b0;
      led_reg      <= 1'b0;
      count_reg    <= '0;
    end else if (state_reg == GRANT) begin
      resp_id_reg  <= winner_reg;
      resp_odd_reg <= parity;
      led_reg      <= parity;
      if (parity && (count_reg != {COUNT_W{1'b1}})) count_reg <= count_reg + 1'b1;
    end
  end

  // One-hot grant decoded straight from the state register.
  for (genvar gi = 0; gi < NREQ; gi++) begin : g_gnt
    assign bus.gnt[gi] = (state_reg == GRANT) && (winner_reg == IDW'(gi));
  end

  assign bus.resp_valid = (state_reg == RESP);
  assign bus.resp_id    = resp_id_reg;
  assign bus.resp_odd   = resp_odd_reg;
  assign bus.led        = led_reg;
  assign bus.odd_count  = count_reg;

endmodule

// File: doc/parity_arbiter.md
Name: parity_arbiter

Overview:
- Shares one combinational 4-bit odd-parity evaluator among NREQ requesters using round-robin arbitration.
- Each transaction captures one requester's nibble, evaluates it, and returns a tagged one-cycle response.
- Drives the board LED with the most recent result and counts odd-parity results.
- Sits between the switch/requester logic and the LED/7-seg outputs in the lab top level.

Parameters:
- NREQ, 4, number of requesters (2..8).
- COUNT_W, 8, width of the saturating odd-result counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- en  in  1  arbitration enable; when low, no new grants are issued.
- req  in  NREQ  per-requester request, level.
- data  in  4*NREQ  nibbles; requester i owns bits [4i+3:4i].
- gnt  out  NREQ  one-hot grant, high for exactly one cycle.
- resp_valid  out  1  one-cycle response strobe.
- resp_id  out  clog2(NREQ)  index of the responding requester.
- resp_odd  out  1  1 = odd number of ones in the captured nibble.
- led  out  1  last resp_odd, held between transactions.
- odd_count  out  COUNT_W  saturating count of odd results.

Behaviour:
- Reset is asynchronous, active-high.
  - All outputs go to 0 immediately.
  - State goes to IDLE.
  - Round-robin pointer goes to 0, so req[0] has top priority.
  - Captured operand is cleared.
- State machine, registered, one state per cycle:
  - IDLE: if en=1 and req!=0, pick the first asserted req at or after the pointer, searching upward with wrap at NREQ.
    - On that edge: capture its nibble, register the winner index, set the pointer to (winner+1) mod NREQ, and go to GRANT.
    - Otherwise stay in IDLE.
  - GRANT: gnt[winner]=1, all other bits 0. Unconditionally go to RESP.
  - RESP: resp_valid=1, resp_id=winner, resp_odd=parity(captured nibble). Unconditionally go to IDLE.
- Outputs that change on entry to RESP:
  - led takes resp_odd and holds until the next RESP.
  - odd_count increments when resp_odd=1, saturating at 2^COUNT_W-1.
- Latency and throughput:
  - req sampled high in IDLE → gnt the next cycle → resp_valid the cycle after.
  - One transaction every 3 cycles at most.
- Requester handshake:
  - data must be valid whenever req is high.
  - req is sampled only in IDLE; changes on req/data during GRANT or RESP are ignored.
  - The requester drops req after seeing its gnt. req still high at the next IDLE counts as a new request.
- en=0 mid-transaction: the in-flight transaction completes normally; only the IDLE decision is blocked.
- resp_id and resp_odd hold their last values when resp_valid=0; consumers qualify them with resp_valid.
- Parity arithmetic: XOR of the 4 captured bits. 0000→0, 1111→0, 0111→1.
- Reset asserted in GRANT or RESP: the transaction is aborted, with no resp_valid and no counter or led update.
- gnt, resp_valid and the counter-increment enable are decoded from the state register, so they never glitch relative to each other.

Decomposition:
- Package parity_arb_pkg:
  - state enum {IDLE, GRANT, RESP} in 2 bits.
  - Default NREQ and COUNT_W.
  - Function for the id width, clog2(NREQ).
- Sub-module odd_parity4: pure combinational 4-in/1-out XOR evaluator, instantiated once on the captured operand. This is the shared resource.
- Round-robin selection is an in-module function; no separate module.

Test Plan:
- Reset: hold rst with random req/data → gnt=0, resp_valid=0, led=0, odd_count=0. Release rst, req=0 → stays idle, all outputs 0.
- Single request: req=0001, data0=0111 → gnt=0001 at cycle+1; resp_valid=1, resp_id=0, resp_odd=1 at cycle+2; led=1, odd_count=1.
- Even parity: req=0100, data2=1111 → gnt=0100, resp_id=2, resp_odd=0, led=0, odd_count unchanged.
- Round robin: req=1111 re-raised after every gnt, data0..3 = 0001, 0011, 0111, 0000 → grant order 0,1,2,3,0; resp_odd sequence 1,0,1,0,1; odd_count=3.
- Enable and saturation: COUNT_W=2, en=1, req0 with data 0001 for 5 transactions → odd_count = 1,2,3,3,3. Drop en during GRANT → that response still arrives, then no further gnt while en=0.
- Reset mid-operation: assert rst in the GRANT cycle → gnt drops immediately and no resp_valid follows. After release with req=1010 → req1 is granted first (pointer back at 0).
